// File: rtl/bios_pkg.sv
// rtl/bios_pkg.sv - shared types, constants and helpers for the BIOS ROM arbiter
//
// Purpose : arbiter state encoding, requester identity, default BIOS base
//           address and the 32-bit byte-reversal helper.
// Ports   : none (package).
package bios_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        BURST,
        ERROR
    } state_e;

    typedef enum logic {
        FETCH_REQ,
        BUS_REQ
    } requester_e;

    localparam logic [31:0] BIOS_BASE_DEFAULT = 32'hF000_0000;

    // The ROM image is little-endian and the CPU is big-endian.
    function automatic logic [31:0] byteswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/bios_rom_arbiter.sv
// rtl/bios_rom_arbiter.sv - shares the combinational BIOS ROM between fetch and bus ports
//
// Purpose : round-robin arbitration between single-word instruction fetches and
//           bus read bursts (1..16 beats), ROM address generation, registered and
//           optionally byte-swapped read data, error response for bus writes and
//           out-of-range bus addresses.
// Ports   : clock, nReset              - clock, async active-low reset
//           fetchRequest/Address       - fetch request in, held until fetchGrant
//           fetchGrant/DataValid/Data  - fetch accept pulse and returned word
//           busRequest/Address/BurstSize/Write - bus request in, held until busGrant
//           busGrant/DataValid/Data/Error/EndTransaction - bus responses
//           romAddress, romData        - word address out, combinational data in
module bios_rom_arbiter
    import bios_pkg::*;
#(
    parameter int          ROM_ADDR_WIDTH = 11,
    parameter logic [31:0] BIOS_BASE      = BIOS_BASE_DEFAULT,
    parameter bit          SWAP_BYTES     = 1'b1
) (
    input  logic                      clock,
    input  logic                      nReset,
    input  logic                      fetchRequest,
    input  logic [31:0]               fetchAddress,
    output logic                      fetchGrant,
    output logic                      fetchDataValid,
    output logic [31:0]               fetchData,
    input  logic                      busRequest,
    input  logic [31:0]               busAddress,
    input  logic [3:0]                busBurstSize,
    input  logic                      busWrite,
    output logic                      busGrant,
    output logic                      busDataValid,
    output logic [31:0]               busData,
    output logic                      busError,
    output logic                      busEndTransaction,
    output logic [ROM_ADDR_WIDTH-1:0] romAddress,
    input  logic [31:0]               romData
);

    // First byte-address bit above the ROM window; bits from here up form the region tag.
    localparam int TAG_LSB = ROM_ADDR_WIDTH + 2;

    state_e                    state, state_next;
    requester_e                last_grant, last_grant_next;
    logic [3:0]                beat_count, beat_count_next;
    logic [ROM_ADDR_WIDTH-1:0] rom_address_next;
    logic                      fetch_grant_next, fetch_valid_next;
    logic [31:0]               fetch_data_next;
    logic                      bus_grant_next, bus_valid_next, bus_error_next, bus_end_next;
    logic [31:0]               bus_data_next;
    logic [31:0]               rom_word;
    logic                      bus_in_range;
    logic                      pick_fetch, pick_bus;
    logic                      unused_addr_bits;

    assign rom_word     = SWAP_BYTES ? byteswap32(romData) : romData;
    assign bus_in_range = (busAddress[31:TAG_LSB] == BIOS_BASE[31:TAG_LSB]);

    // Fetch wins when alone or when the bus had the previous grant.
    assign pick_fetch = fetchRequest && (!busRequest || last_grant == BUS_REQ);
    assign pick_bus   = busRequest && !pick_fetch;

    // Fetch addresses are never range-checked; byte-lane bits are don't-care.
    assign unused_addr_bits = ^{fetchAddress[31:TAG_LSB], fetchAddress[1:0], busAddress[1:0]};

    always_comb begin
        state_next       = state;
        last_grant_next  = last_grant;
        beat_count_next  = beat_count;
        rom_address_next = romAddress;
        fetch_grant_next = 1'b0;
        fetch_valid_next = 1'b0;
        fetch_data_next  = fetchData;
        bus_grant_next   = 1'b0;
        bus_valid_next   = 1'b0;
        bus_data_next    = busData;
        bus_error_next   = 1'b0;
        bus_end_next     = 1'b0;

        case (state)
            IDLE: begin
                if (pick_fetch) begin
                    state_next       = FETCH;
                    last_grant_next  = FETCH_REQ;
                    fetch_grant_next = 1'b1;
                    rom_address_next = fetchAddress[TAG_LSB-1:2];
                end else if (pick_bus) begin
                    last_grant_next = BUS_REQ;
                    bus_grant_next  = 1'b1;
                    if (busWrite || !bus_in_range) begin
                        state_next = ERROR;
                    end else begin
                        state_next       = BURST;
                        rom_address_next = busAddress[TAG_LSB-1:2];
                        beat_count_next  = busBurstSize;
                    end
                end
            end
            FETCH: begin
                fetch_valid_next = 1'b1;
                fetch_data_next  = rom_word;
                state_next       = IDLE;
            end
            BURST: begin
                bus_valid_next   = 1'b1;
                bus_data_next    = rom_word;
                // Natural modulo wrap at the top of the ROM.
                rom_address_next = romAddress + ROM_ADDR_WIDTH'(1);
                if (beat_count == 4'd0) begin
                    bus_end_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    beat_count_next = beat_count - 4'd1;
                end
            end
            ERROR: begin
                bus_error_next = 1'b1;
                bus_end_next   = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state             <= IDLE;
            last_grant        <= BUS_REQ;
            beat_count        <= 4'd0;
            romAddress        <= '0;
            fetchGrant        <= 1'b0;
            fetchDataValid    <= 1'b0;
            fetchData         <= 32'd0;
            busGrant          <= 1'b0;
            busDataValid      <= 1'b0;
            busData           <= 32'd0;
            busError          <= 1'b0;
            busEndTransaction <= 1'b0;
        end else begin
            state             <= state_next;
            last_grant        <= last_grant_next;
            beat_count        <= beat_count_next;
            romAddress        <= rom_address_next;
            fetchGrant        <= fetch_grant_next;
            fetchDataValid    <= fetch_valid_next;
            fetchData         <= fetch_data_next;
            busGrant          <= bus_grant_next;
            busDataValid      <= bus_valid_next;
            busData           <= bus_data_next;
            busError          <= bus_error_next;
            busEndTransaction <= bus_end_next;
        end
    end

endmodule

// File: doc/bios_rom_arbiter.md
Name: bios_rom_arbiter

Overview:
Shares the 2048x32 combinational BIOS ROM between two requesters: the CPU instruction-fetch port and the system-bus slave port. The fetch port issues single-word reads; the bus port issues bursts of up to 16 words. The block drives the ROM address, registers the ROM output, and returns it byte-swapped, because the ROM image is stored little-endian and the CPU is big-endian. Illegal bus accesses (writes, out-of-range addresses) get an error response. It sits between the CPU/bus and biosRom.

Parameters:
ROM_ADDR_WIDTH, 11, word-address width of the ROM (2^11 words)
BIOS_BASE, 32'hF0000000, byte base address of the BIOS region; must be aligned to the region size
SWAP_BYTES, 1, 1 = reverse byte order of romData on output; 0 = pass through

Ports:
clock  in  1  system clock
nReset  in  1  asynchronous active-low reset
fetchRequest  in  1  fetch read request; held until fetchGrant
fetchAddress  in  32  fetch byte address; bits [1:0] ignored
fetchGrant  out  1  one-cycle pulse: fetch request accepted
fetchDataValid  out  1  one-cycle pulse: fetchData valid
fetchData  out  32  fetched word
busRequest  in  1  bus transaction request; held until busGrant
busAddress  in  32  bus start byte address
busBurstSize  in  4  beats minus 1 (0 = 1 beat, 15 = 16 beats)
busWrite  in  1  1 = write (always illegal)
busGrant  out  1  one-cycle pulse: bus request accepted
busDataValid  out  1  one beat valid on busData
busData  out  32  burst read data
busError  out  1  one-cycle error pulse
busEndTransaction  out  1  one-cycle pulse marking the last beat or the error cycle
romAddress  out  ROM_ADDR_WIDTH  word address to biosRom
romData  in  32  combinational ROM output

Behaviour:
- Reset (nReset low, asynchronous): state=IDLE, all outputs 0, romAddress=0, lastGrant=BUS (so fetch wins the first tie). Reset mid-transaction aborts it immediately; no trailing valid/end pulses.
- States: IDLE, FETCH, BURST, ERROR.
- IDLE, request sampled at cycle T:
  - Both requesting: grant the side opposite lastGrant (round-robin); otherwise grant the lone requester.
  - A grant updates lastGrant.
- Grant timing: grant pulses at T+1; romAddress is loaded at T+1.
- Fetch: IDLE -> FETCH. romAddress = fetchAddress[ROM_ADDR_WIDTH+1:2]. fetchData registered from romData; fetchDataValid=1 at T+2. Then back to IDLE.
- Range check: an address is in range when addr[31:ROM_ADDR_WIDTH+2] == BIOS_BASE[31:ROM_ADDR_WIDTH+2].
- An out-of-range fetch still returns ROM data; no error signalling exists on the fetch port.
- Bus read, in range: IDLE -> BURST. beatCount = busBurstSize, latched with the start address at grant.
  - Each cycle romAddress increments by 1, wrapping modulo 2^ROM_ADDR_WIDTH (0x7FF -> 0x000).
  - Beats appear at T+2 .. T+2+busBurstSize, with busDataValid high on each.
  - busEndTransaction coincides with the last beat; then IDLE.
  - No backpressure: the bus consumes one beat per cycle.
- Bus write, or out-of-range bus address: IDLE -> ERROR. At T+2, busError=1 and busEndTransaction=1, busDataValid=0; then IDLE.
- After every transaction the block spends at least one cycle in IDLE, so a back-to-back request is granted no earlier than 1 cycle after the previous end.
- A request arriving mid-transaction waits. Its grant follows round-robin in the next IDLE.
- Data outputs hold their last value when their valid is low.
- Byte swap: out = {d[7:0], d[15:8], d[23:16], d[31:24]} when SWAP_BYTES=1.

Decomposition:
- Package bios_pkg holds:
  - state enum (IDLE, FETCH, BURST, ERROR)
  - requester enum (FETCH_REQ, BUS_REQ)
  - BIOS_BASE default constant
  - byteswap32 function
- Single module, no sub-module. The range check and byte swap are small combinational logic inline. biosRom is instantiated by the parent, not inside this block.

Test Plan:
- Reset: hold nReset=0 with random inputs -> all outputs 0. Release, then fetchRequest at 0xF0000000 -> fetchGrant at T+1, fetchDataValid with fetchData=0xDEADBEEF at T+2 (ROM word 0 = 0xEFBEADDE).
- Bus burst with wrap: busAddress=0xF0001FF8 (word 0x7FE), busBurstSize=3 -> romAddress sequence 0x7FE, 0x7FF, 0x000, 0x001; busData = 0x00000000, 0x00000000, 0xDEADBEEF, 0x15000000; busEndTransaction on the 4th beat.
- Contention: fetch and bus both request continuously -> grants alternate fetch, bus, fetch, bus, starting with fetch after reset; neither requester starves.
- Errors: busWrite=1 at 0xF0000000 -> busError and busEndTransaction at T+2, no busDataValid. busAddress=0x00000000 read -> same error response.
- Reset mid-burst: assert nReset during the 3rd beat of a 16-beat burst -> outputs 0 immediately. After release, a fresh fetch completes normally with 2-cycle latency.
